// File: rtl/tow_scorer.sv
// Tug of War round scorer: rope position, win detection and LED bar drive.
// States:  ARMED | waiting for the first button edge of a round
//          HOLD  | round scored, waiting for both buttons up and go-light off
//          WIN   | game over, winner half of the bar blinks on slowenable
module tow_scorer #(
  parameter int HALF_SPAN = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   slowenable,
  input  logic                   leds_on,
  input  logic                   leds_ctrl,
  input  logic                   clear,
  input  logic                   pbl,
  input  logic                   pbr,
  output logic                   winrnd,
  output logic                   win_l,
  output logic                   win_r,
  output logic [2*HALF_SPAN:0]   leds
);

  localparam int W  = 2*HALF_SPAN + 1;
  localparam int PW = $clog2(HALF_SPAN + 2) + 1;
  localparam logic signed [PW-1:0] POS_WIN = PW'(HALF_SPAN + 1);
  localparam logic signed [PW-1:0] ONE     = PW'(1);
  localparam logic [W-1:0]         CENTRE  = W'(1) << HALF_SPAN;

  typedef enum logic [1:0] {ARMED, HOLD, WIN} state_t;

  state_t               state_q, state_d;
  logic signed [PW-1:0] pos_q, pos_d;
  logic                 pbl_q, pbr_q;
  logic                 blink_q, blink_d;
  logic                 winrnd_d, win_l_d, win_r_d;
  logic [W-1:0]         leds_d;
  logic                 press_l, press_r;
  int                   idx;

  always_comb begin
    press_l  = pbl & ~pbl_q;
    press_r  = pbr & ~pbr_q;
    state_d  = state_q;
    pos_d    = pos_q;
    blink_d  = blink_q;
    winrnd_d = 1'b0;
    win_l_d  = win_l;
    win_r_d  = win_r;

    if (clear) begin
      state_d = HOLD;
      pos_d   = '0;
      blink_d = 1'b1;
      win_l_d = 1'b0;
      win_r_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (!pbl && !pbr && !leds_on) state_d = ARMED;
        end
        ARMED: begin
          if (press_l || press_r) begin
            winrnd_d = 1'b1;
            state_d  = HOLD;
            // an early press moves the rope against the player who pressed
            if (press_l && !press_r)
              pos_d = leds_on ? pos_q + ONE : pos_q - ONE;
            else if (press_r && !press_l)
              pos_d = leds_on ? pos_q - ONE : pos_q + ONE;
            if (pos_d == POS_WIN) begin
              win_l_d = 1'b1;
              state_d = WIN;
            end else if (pos_d == -POS_WIN) begin
              win_r_d = 1'b1;
              state_d = WIN;
            end
          end
        end
        WIN: begin
          if (slowenable) blink_d = ~blink_q;
        end
        default: state_d = HOLD;
      endcase
    end

    idx    = HALF_SPAN + int'(pos_d);
    leds_d = '0;
    for (int i = 0; i < W; i++) begin
      if (state_d == WIN)
        leds_d[i] = blink_d & (win_l_d ? (i >= HALF_SPAN) : (i <= HALF_SPAN));
      else if (leds_ctrl)
        leds_d[i] = 1'b1;
      else
        leds_d[i] = (i == idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      pos_q   <= '0;
      pbl_q   <= 1'b0;
      pbr_q   <= 1'b0;
      blink_q <= 1'b1;
      winrnd  <= 1'b0;
      win_l   <= 1'b0;
      win_r   <= 1'b0;
      leds    <= CENTRE;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      pbl_q   <= pbl;
      pbr_q   <= pbr;
      blink_q <= blink_d;
      winrnd  <= winrnd_d;
      win_l   <= win_l_d;
      win_r   <= win_r_d;
      leds    <= leds_d;
    end
  end

endmodule

// File: tb/tb_tow_scorer.sv
// Bench for tow_scorer: per-scenario stimulus tables, expected outputs queued
// on drive and popped after the clock edge that registers them.
module tb_tow_scorer;

  logic       clk = 1'b0;
  logic       rst, slowenable, leds_on, leds_ctrl, clear, pbl, pbr;
  logic       winrnd, win_l, win_r;
  logic [6:0] leds;

  int checks = 0;
  int errors = 0;

  // in = {rst,pbl,pbr,leds_on,leds_ctrl,clear,slowenable}
  // ex = {leds[6:0],winrnd,win_l,win_r}
  typedef struct {
    logic [6:0] in;
    logic [9:0] ex;
  } row_t;

  logic [9:0] sb_q[$];

  tow_scorer #(.HALF_SPAN(3)) dut (
    .clk(clk), .rst(rst), .slowenable(slowenable), .leds_on(leds_on),
    .leds_ctrl(leds_ctrl), .clear(clear), .pbl(pbl), .pbr(pbr),
    .winrnd(winrnd), .win_l(win_l), .win_r(win_r), .leds(leds)
  );

  always #5 clk = ~clk;

  function automatic row_t r(input logic [6:0] in, input logic [9:0] ex);
    row_t x;
    x.in = in;
    x.ex = ex;
    return x;
  endfunction

  // drive one cycle of inputs, queue the outputs expected after the edge
  task automatic apply(input row_t rw);
    {rst, pbl, pbr, leds_on, leds_ctrl, clear, slowenable} = rw.in;
    sb_q.push_back(rw.ex);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b1000000, {7'b0001000, 3'b000}));
    for (int k = 0; k < 5; k++) rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_reset[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_legit_left();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b1000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b0010000, 3'b100}));
    for (int k = 0; k < 10; k++) rows.push_back(r(7'b0101000, {7'b0010000, 3'b000}));
    rows.push_back(r(7'b0000100, {7'b1111111, 3'b000}));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_legit_left[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_early_and_hold();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b1000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0010000, {7'b0010000, 3'b100}));  // early right: +1
    rows.push_back(r(7'b0110000, {7'b0010000, 3'b000}));  // pbl edge, pbr held
    rows.push_back(r(7'b0111000, {7'b0010000, 3'b000}));
    rows.push_back(r(7'b0001000, {7'b0010000, 3'b000}));  // released, go-light on
    rows.push_back(r(7'b0101000, {7'b0010000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0010000, 3'b000}));  // arms
    rows.push_back(r(7'b0101000, {7'b0100000, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b0100000, 3'b000}));
    rows.push_back(r(7'b0100000, {7'b0010000, 3'b100}));  // early left penalty
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_early_and_hold[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_tie();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b1000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0111000, {7'b0001000, 3'b100}));
    rows.push_back(r(7'b0111000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0110000, {7'b0001000, 3'b100}));  // early tie
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_tie[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_win_right();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b1000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0011000, {7'b0000100, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b0000100, 3'b000}));
    rows.push_back(r(7'b0011000, {7'b0000010, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b0000010, 3'b000}));
    rows.push_back(r(7'b0011000, {7'b0000001, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b0000001, 3'b000}));
    rows.push_back(r(7'b0011000, {7'b0001111, 3'b101}));
    rows.push_back(r(7'b0000000, {7'b0001111, 3'b001}));
    rows.push_back(r(7'b0000001, {7'b0000000, 3'b001}));
    rows.push_back(r(7'b0000000, {7'b0000000, 3'b001}));
    rows.push_back(r(7'b0000001, {7'b0001111, 3'b001}));
    rows.push_back(r(7'b0101100, {7'b0001111, 3'b001}));
    rows.push_back(r(7'b0010101, {7'b0000000, 3'b001}));
    rows.push_back(r(7'b0000100, {7'b0000000, 3'b001}));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_win_right[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_clear();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b0101010, {7'b0001000, 3'b000}));  // clear beats pbl edge
    rows.push_back(r(7'b0101000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0001100, {7'b1111111, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0100000, {7'b0000100, 3'b100}));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_clear[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  task automatic test_win_left_reset_held();
    row_t rows[$];
    logic [9:0] got, exp;
    rows.push_back(r(7'b1000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b0010000, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b0010000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b0100000, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b0100000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b1000000, 3'b100}));
    rows.push_back(r(7'b0000000, {7'b1000000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b1111000, 3'b110}));
    rows.push_back(r(7'b0100001, {7'b0000000, 3'b010}));
    rows.push_back(r(7'b1100000, {7'b0001000, 3'b000}));  // reset, pbl held
    rows.push_back(r(7'b0100000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0000000, {7'b0001000, 3'b000}));
    rows.push_back(r(7'b0101000, {7'b0010000, 3'b100}));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = {leds, winrnd, win_l, win_r};
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL test_win_left_reset_held[%0d]: got %b required %b", i, got, exp);
      end
    end
  endtask

  initial begin
    {rst, pbl, pbr, leds_on, leds_ctrl, clear, slowenable} = 7'b1000000;
    test_reset();
    test_legit_left();
    test_early_and_hold();
    test_tie();
    test_win_right();
    test_clear();
    test_win_left_reset_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
